// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers, IME with delayed EI, and the acknowledge/vector dispatch FSM.
// Build option: define INTCTRL_EDGE_DETECT_EN to set IF on rising request edges instead of levels.
module interrupt_controller (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic [4:0]  i_Int_Req,
  input  logic [15:0] i_Addr,
  input  logic [7:0]  i_Data,
  input  logic        i_Write,
  output logic [7:0]  o_Data,
  output logic        o_Selected,
  input  logic        i_EI,
  input  logic        i_DI,
  input  logic        i_RETI,
  input  logic        i_Instr_Boundary,
  output logic [4:0]  o_Interrupts,
  output logic        o_Wake,
  input  logic        i_Handle_Interrupt,
  output logic [7:0]  o_Vector,
  output logic        o_Vector_Valid,
  input  logic        i_Vector_Taken,
  output logic [1:0]  o_Debug_State
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, VEC = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q;
  logic        ime_q, ime_d;
  logic        ime_pending_q, ime_pending_d;
  logic [2:0]  idx_q, first_idx;
  logic        cancel_q, none_pending;
  logic [4:0]  pending, req_set, dispatch_clear;
  logic        write_if, write_ie;

  assign write_if = i_Write && (i_Addr == 16'hFF0F);
  assign write_ie = i_Write && (i_Addr == 16'hFFFF);
  assign pending  = if_q & ie_q[4:0];

`ifdef INTCTRL_EDGE_DETECT_EN
  logic [4:0] prev_req_q;
  assign req_set = i_Int_Req & ~prev_req_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)         prev_req_q <= 5'b0;
    else if (i_Enable) prev_req_q <= i_Int_Req;
  end
`else
  assign req_set = i_Int_Req;
`endif

  // Lowest set bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    first_idx    = 3'd0;
    none_pending = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) begin
        first_idx    = 3'(i);
        none_pending = 1'b0;
      end
    end
  end

  assign dispatch_clear = (state_q == ACK && !cancel_q) ? (5'b00001 << idx_q) : 5'b0;
  assign if_d = ((write_if ? i_Data[4:0] : if_q) & ~dispatch_clear) | req_set;

  always_comb begin
    ime_d         = ime_q;
    ime_pending_d = ime_pending_q;
    if (i_Instr_Boundary && ime_pending_q) begin
      ime_d         = 1'b1;
      ime_pending_d = 1'b0;
    end
    if (i_EI)   ime_pending_d = 1'b1;
    if (i_RETI) ime_d = 1'b1;
    if (state_q == ACK || i_DI) begin
      ime_d         = 1'b0;
      ime_pending_d = 1'b0;
    end
  end

  // Vector handshake: o_Vector_Valid rises with o_Vector stable and both hold until the
  // control unit pulses i_Vector_Taken; Valid then drops on the next enabled edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_Handle_Interrupt) state_d = ACK;
      ACK:     state_d = VEC;
      VEC:     if (i_Vector_Taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q        <= IDLE;
      if_q           <= 5'b0;
      ie_q           <= 8'h00;
      ime_q          <= 1'b0;
      ime_pending_q  <= 1'b0;
      idx_q          <= 3'd0;
      cancel_q       <= 1'b0;
      o_Vector       <= 8'h00;
      o_Vector_Valid <= 1'b0;
    end else if (i_Enable) begin
      state_q       <= state_d;
      if_q          <= if_d;
      ime_q         <= ime_d;
      ime_pending_q <= ime_pending_d;
      if (write_ie) ie_q <= i_Data;
      if (state_q == IDLE && i_Handle_Interrupt) begin
        idx_q    <= first_idx;
        cancel_q <= none_pending;
      end
      if (state_q == ACK) begin
        o_Vector       <= cancel_q ? 8'h00 : 8'h40 + {2'b00, idx_q, 3'b000};
        o_Vector_Valid <= 1'b1;
      end
      if (state_q == VEC && i_Vector_Taken) o_Vector_Valid <= 1'b0;
    end
  end

  always_comb begin
    o_Data = 8'h00;
    if (i_Addr == 16'hFF0F)      o_Data = {3'b111, if_q};
    else if (i_Addr == 16'hFFFF) o_Data = ie_q;
  end

  assign o_Selected    = (i_Addr == 16'hFF0F) || (i_Addr == 16'hFFFF);
  assign o_Interrupts  = ime_q ? pending : 5'b0;
  assign o_Wake        = |pending;
  assign o_Debug_State = state_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt source for the CPU control unit: holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME master enable, and presents masked pending requests on the control unit's 5-bit interrupt input. When the control unit asserts its handle-interrupt line, this block runs the acknowledge/vector handshake: it picks the highest-priority source, clears its IF bit, clears IME and supplies the restart vector. It sits beside the control unit and on the 8-bit memory-mapped I/O bus.

## Interface
- No parameters.
- i_Clk  in  1  system clock, all state on rising edge
- i_Rst  in  1  reset, asynchronous, active-high
- i_Enable  in  1  clock enable; state changes only when high
- i_Int_Req  in  5  peripheral requests; bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad
- i_Addr  in  16  bus address
- i_Data  in  8  bus write data
- i_Write  in  1  bus write strobe
- o_Data  out  8  read data; valid combinationally for 0xFF0F/0xFFFF, else 0x00
- o_Selected  out  1  high when i_Addr is 0xFF0F or 0xFFFF
- i_EI / i_DI / i_RETI  in  1 each  opcode strobes from the control unit
- i_Instr_Boundary  in  1  one-cycle pulse at the end of each opcode
- o_Interrupts  out  5  (IF & IE) when IME=1, else 0; to control unit
- o_Wake  out  1  |(IF & IE) regardless of IME (HALT exit)
- i_Handle_Interrupt  in  1  dispatch request from control unit
- o_Vector  out  8  restart address low byte
- o_Vector_Valid  out  1  vector ready
- i_Vector_Taken  in  1  control unit has consumed the vector

## Operation
- Reset values: IF=0x00, IE=0x00, IME=0, ime_pending=0, FSM=IDLE, o_Vector=0x00, o_Vector_Valid=0; o_Interrupts=0, o_Wake=0.
- IF reads as {3'b111, IF[4:0]}; IE is stored and read as 8 bits. Only IE[4:0] take part in masking.
- IF update each enabled cycle: next = (i_Write to 0xFF0F ? i_Data[4:0] : IF) & ~dispatch_clear | req_set. Requests win over both CPU writes and dispatch clears for the same bit.
- EI sets ime_pending. At the next i_Instr_Boundary with ime_pending set, IME becomes 1 and ime_pending clears. EI and the boundary in the same cycle only set ime_pending, which delays enabling by one instruction.
- DI clears IME and ime_pending immediately. RETI sets IME immediately. DI wins over an EI or RETI in the same cycle.
- FSM states:
  - IDLE: when i_Handle_Interrupt is high, latch idx = lowest set bit of (IF & IE) and go to ACK. If none is set, latch "cancel" and go to ACK.
  - ACK (1 cycle): clear IF[idx] unless cancelled, clear IME and ime_pending, set o_Vector = cancel ? 0x00 : 0x40 + 8*idx, assert o_Vector_Valid, go to VEC.
  - VEC: hold o_Vector and o_Vector_Valid until i_Vector_Taken, then deassert Valid and return to IDLE.
- i_Handle_Interrupt is ignored outside IDLE.

## Timing
- A request sets IF on the clock edge that samples it. o_Interrupts and o_Wake are combinational from the registers, so they are visible the same cycle IF updates.
- Dispatch latency: i_Handle_Interrupt sampled in IDLE → o_Vector_Valid high 2 edges later (IDLE→ACK→VEC). The IF clear is visible 2 edges after the request.
- i_Vector_Taken in the first VEC cycle → IDLE on the next edge. Minimum dispatch is 3 cycles.
- i_Enable low freezes all state and the FSM; outputs hold.
- i_Rst mid-dispatch returns to IDLE immediately and drops o_Vector_Valid. The IF bit is not cleared if reset arrives before ACK completes.
- Priority is fixed: lower index wins.

## Configuration
- INTCTRL_EDGE_DETECT_EN defined: IF[n] is set only on a rising edge of i_Int_Req[n], using an internal 5-bit previous-value register that resets to 0.
- Not defined: any cycle with i_Int_Req[n] high sets IF[n] (level-sensitive), so a held request re-sets IF immediately after a dispatch clear.

## Test plan
- Reset, pulse i_Int_Req=5'b00100 with IE=0x04, IME=0 → IF reads 0xE4, o_Wake=1, o_Interrupts=0.
- IE=0x1F, IME=1, IF=0x0A, assert i_Handle_Interrupt → o_Vector=0x48 with Valid 2 edges later, IF reads 0xE8, IME=0; i_Vector_Taken → IDLE.
- EI, then i_Instr_Boundary on the next cycle, with IF&IE=0x01 → o_Interrupts stays 0 until after the boundary edge, then reads 0x01.
- In the same cycle, write IF=0x00 and raise i_Int_Req[4] → IF reads 0xF0.
- Handle request with IF&IE=0 → o_Vector=0x00 with Valid, IF unchanged.
- Assert i_Rst while in VEC → o_Vector_Valid=0, FSM in IDLE, IF=0xE0, IE=0x00 on readback.
